// File: rtl/zmod_tx_pkg.sv
// rtl/zmod_tx_pkg.sv - shared types and widths for the Zmod TX reset sequencer
package zmod_tx_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    STABLE     = 3'd1,
    SERDES_RST = 3'd2,
    CAL        = 3'd3,
    RUN        = 3'd4
  } tx_state_t;

  localparam int LOST_CNT_W  = 8;
  localparam int RETRY_CNT_W = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/zmod_sync2.sv
// rtl/zmod_sync2.sv - generic two-flop synchroniser with synchronous reset
module zmod_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [W-1:0] meta;
  (* ASYNC_REG = "TRUE" *) logic [W-1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= d;
      sync <= meta;
    end
  end

  assign q = sync;

endmodule

// File: rtl/zmod_tx_rstseq.sv
// rtl/zmod_tx_rstseq.sv - PLL lock monitor and SERDES reset / calibration bring-up sequencer
module zmod_tx_rstseq
  import zmod_tx_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int SERDES_RST_CYCLES  = 16,
  parameter int CAL_TIMEOUT        = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   cal_done,
  output logic                   serdes_rst,
  output logic                   cal_start,
  output logic                   tx_enable,
  output logic [LOST_CNT_W-1:0]  lock_lost_count,
  output logic [RETRY_CNT_W-1:0] cal_retry_count,
  output logic [2:0]             state
);

  localparam int CW = $clog2(max3(LOCK_STABLE_CYCLES, SERDES_RST_CYCLES, CAL_TIMEOUT)) + 1;
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] RST_LAST    = CW'(SERDES_RST_CYCLES - 1);
  localparam logic [CW-1:0] CAL_LAST    = CW'(CAL_TIMEOUT - 1);

  tx_state_t     st;
  logic [CW-1:0] cnt;
  logic          locked_s;

  zmod_sync2 #(.W(1)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st              <= WAIT_LOCK;
      cnt             <= '0;
      serdes_rst      <= 1'b1;
      cal_start       <= 1'b0;
      tx_enable       <= 1'b0;
      lock_lost_count <= '0;
      cal_retry_count <= '0;
    end else if (st != WAIT_LOCK && !locked_s) begin
      // A drop seen while still debouncing in STABLE is a glitch, not a real loss
      st         <= WAIT_LOCK;
      cnt        <= '0;
      serdes_rst <= 1'b1;
      cal_start  <= 1'b0;
      tx_enable  <= 1'b0;
      if (st != STABLE && lock_lost_count != '1)
        lock_lost_count <= lock_lost_count + LOST_CNT_W'(1);
    end else begin
      case (st)
        WAIT_LOCK: begin
          cal_start <= 1'b0;
          if (locked_s) begin
            st  <= STABLE;
            cnt <= '0;
          end
        end
        STABLE: begin
          if (cnt == STABLE_LAST) begin
            st  <= SERDES_RST;
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SERDES_RST: begin
          if (cnt == RST_LAST) begin
            st         <= CAL;
            cnt        <= '0;
            serdes_rst <= 1'b0;
            cal_start  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CAL: begin
          cal_start <= 1'b0;
          if (cal_done) begin
            st        <= RUN;
            cnt       <= '0;
            tx_enable <= 1'b1;
          end else if (cnt == CAL_LAST) begin
            st         <= SERDES_RST;
            cnt        <= '0;
            serdes_rst <= 1'b1;
            if (cal_retry_count != '1)
              cal_retry_count <= cal_retry_count + RETRY_CNT_W'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RUN: begin
          cal_start <= 1'b0;
        end
        default: begin
          st         <= WAIT_LOCK;
          cnt        <= '0;
          serdes_rst <= 1'b1;
          cal_start  <= 1'b0;
          tx_enable  <= 1'b0;
        end
      endcase
    end
  end

  assign state = st;

endmodule
